dmem_port_arbiter: RTL and testbench

//   Shares the single data-memory port between the pipeline MEM stage (port P) and a debug/loader

---
 rtl/dmem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
//
// Shares the single data-memory port between the pipeline MEM stage (port P)
// and a debug/loader master (port D). P wins by default; D wins when P is idle,
// or once P has taken STARVE_MAX consecutive slots while D was waiting. With
// STARVE_MAX = 0, D always wins when it is eligible. A D access completes with
// a one-cycle d_ack pulse in the cycle after its grant. D cannot be granted
// again in that cycle.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   p_req/p_we/p_wmask/
//   p_addr/p_wdata           pipeline access request (load or store)
//   p_rdata                  pipeline read data (combinational from DMEM)
//   p_stall                  P lost the port this cycle; the MEM stage must hold
//   d_req/d_we/d_wmask/
//   d_addr/d_wdata           debug access request (level, held until d_ack)
//   d_ack                    one-cycle completion pulse for a D access
//   d_rdata                  registered D read data, held after d_ack
//   m_we/m_wmask/m_addr/
//   m_wdata                  DMEM command (combinational from the winner)
//   m_rdata                  DMEM combinational read data
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int AW         = 30,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          p_req,
    input  logic          p_we,
    input  logic [3:0]    p_wmask,
    input  logic [AW-1:0] p_addr,
    input  logic [31:0]   p_wdata,
    output logic [31:0]   p_rdata,
    output logic          p_stall,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [3:0]    d_wmask,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ack,
    output logic [31:0]   d_rdata,

    output logic          m_we,
    output logic [3:0]    m_wmask,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic [31:0]   m_rdata
);

    // The counter must hold the value STARVE_MAX. It needs at least one bit even
    // when STARVE_MAX = 0. In that case it stays at zero and D is always treated
    // as starved.
    localparam int            CW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);

    // FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;   // D may be granted
    localparam logic [0:0] ST_ACK  = 1'b1;   // d_ack cycle, D blocked

    logic [0:0]    state_r;
    logic [0:0]    state_nxt_s;
    logic [CW-1:0] starve_cnt_r;
    logic [CW-1:0] starve_cnt_nxt_s;
    logic          d_ack_r;
    logic [31:0]   d_rdata_r;

    logic          d_eligible_s;
    logic          starved_s;
    logic          gnt_d_s;

    // Grant decision: P wins unless it is idle or has starved D long enough
    always_comb begin
        d_eligible_s = (state_r == ST_IDLE);
        starved_s    = (starve_cnt_r == STARVE_LIM);
        gnt_d_s      = d_eligible_s & d_req & (~p_req | starved_s);
    end

    // Port mux onto DMEM. The write enable is forced low in reset so that a
    // store caught by an asserting reset never reaches memory.
    always_comb begin
        m_we    = 1'b0;
        m_wmask = p_wmask;
        m_addr  = p_addr;
        m_wdata = p_wdata;
        if (gnt_d_s) begin
            m_wmask = d_wmask;
            m_addr  = d_addr;
            m_wdata = d_wdata;
            m_we    = d_we;
        end else begin
            m_we    = p_req & p_we;
        end
        if (rst) begin
            m_we = 1'b0;
        end else begin
            m_we = m_we;
        end
    end

    // Pipeline-side responses; DMEM read is combinational so data passes straight through
    always_comb begin
        p_rdata = m_rdata;
        p_stall = ~rst & p_req & gnt_d_s;
    end

    // Next state: a D grant always spends exactly one cycle in ACK
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (gnt_d_s) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACK:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Starvation counter: counts P wins over a waiting, eligible D. It holds
    // through the ACK cycle and clears on a D win or when D withdraws.
    always_comb begin
        starve_cnt_nxt_s = starve_cnt_r;
        if (gnt_d_s || !d_req) begin
            starve_cnt_nxt_s = CNT_ZERO;
        end else if (d_eligible_s && p_req && !starved_s) begin
            starve_cnt_nxt_s = starve_cnt_r + CNT_ONE;
        end else begin
            starve_cnt_nxt_s = starve_cnt_r;
        end
    end

    // State, counter and D response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            starve_cnt_r <= CNT_ZERO;
            d_ack_r      <= 1'b0;
            d_rdata_r    <= 32'h0000_0000;
        end else begin
            state_r      <= state_nxt_s;
            starve_cnt_r <= starve_cnt_nxt_s;
            d_ack_r      <= gnt_d_s;
            if (gnt_d_s) begin
                d_rdata_r <= m_rdata;
            end else begin
                d_rdata_r <= d_rdata_r;
            end
        end
    end

    // D response outputs come straight from registers
    always_comb begin
        d_ack   = d_ack_r;
        d_rdata = d_rdata_r;
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    localparam int SMAX = 4;

    logic        clk;
    logic        rst;
    logic        p_req, p_we, d_req, d_we;
    logic [3:0]  p_wmask, d_wmask;
    logic [29:0] p_addr, d_addr;
    logic [31:0] p_wdata, d_wdata;

    logic [31:0] p_rdata, d_rdata, m_wdata, m_rdata;
    logic        p_stall, d_ack, m_we;
    logic [3:0]  m_wmask;
    logic [29:0] m_addr;

    logic [31:0] p_rdata0, d_rdata0, m_wdata0, m_rdata0;
    logic        p_stall0, d_ack0, m_we0;
    logic [3:0]  m_wmask0;
    logic [29:0] m_addr0;

    logic [31:0] mem [0:63];
    logic        mem_init;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [31:0] ref_mem [0:63];
    logic        in_ack, in_ack0, last_stall, pend_new;
    int          wait_cnt;
    logic [31:0] exp_drdata, exp_drdata0;

    dmem_port_arbiter #(.AW(30), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_wmask(p_wmask), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_stall(p_stall),
        .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_we(m_we), .m_wmask(m_wmask), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    dmem_port_arbiter #(.AW(30), .STARVE_MAX(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .p_req(p_req), .p_we(p_we), .p_wmask(p_wmask), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_rdata(p_rdata0), .p_stall(p_stall0),
        .d_req(d_req), .d_we(d_we), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack0), .d_rdata(d_rdata0),
        .m_we(m_we0), .m_wmask(m_wmask0), .m_addr(m_addr0), .m_wdata(m_wdata0), .m_rdata(m_rdata0)
    );

    function automatic logic [31:0] init_val(input int i);
        if (i == 16) return 32'h1234_5678;
        return (32'(i) * 32'h0101_0101) ^ 32'h0F0F_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] mask);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
        return r;
    endfunction

    // the second instance sees a fixed address-derived memory image
    function automatic logic [31:0] rom0(input logic [29:0] a);
        return {2'b00, a} ^ 32'h5A5A_0000;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_rdata  = mem[m_addr[5:0]];
    assign m_rdata0 = rom0(m_addr0);

    // behavioural DMEM for the main instance
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_val(i);
        end else if (m_we) begin
            mem[m_addr[5:0]] <= merge(mem[m_addr[5:0]], m_wdata, m_wmask);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: entered at posedge+1 with inputs applied; checks at the
    // negedge, then advances the model across the edge and returns at posedge+1.
    task automatic cycle(input bit rst_mid);
        logic g, g0;
        if (rst_mid) begin
            #1 rst = 1'b1;
            #3;
        end else begin
            #4;
        end
        g  = !in_ack  && d_req && (!p_req || wait_cnt >= SMAX);
        g0 = !in_ack0 && d_req;
        if (rst_mid) begin
            chk("rst_m_we",     32'(m_we),     32'h0);
            chk("rst_p_stall",  32'(p_stall),  32'h0);
            chk("rst_d_ack",    32'(d_ack),    32'h0);
            chk("rst_d_rdata",  d_rdata,       32'h0);
            chk("rst_m_we0",    32'(m_we0),    32'h0);
            chk("rst_p_stall0", 32'(p_stall0), 32'h0);
        end else begin
            chk("d_ack",   32'(d_ack),   32'(in_ack));
            chk("d_rdata", d_rdata,      exp_drdata);
            chk("p_stall", 32'(p_stall), 32'(p_req && g));
            chk("m_we",    32'(m_we),    32'(g ? d_we : (p_req && p_we)));
            if (g || p_req) begin
                chk("m_addr",  {2'b00, m_addr}, {2'b00, (g ? d_addr : p_addr)});
                chk("m_wmask", 32'(m_wmask),    32'(g ? d_wmask : p_wmask));
                chk("m_wdata", m_wdata,         g ? d_wdata : p_wdata);
            end
            if (p_req && !g) chk("p_rdata", p_rdata, ref_mem[p_addr[5:0]]);
            chk("d_ack0",   32'(d_ack0),   32'(in_ack0));
            chk("d_rdata0", d_rdata0,      exp_drdata0);
            chk("p_stall0", 32'(p_stall0), 32'(p_req && g0));
            chk("m_we0",    32'(m_we0),    32'(g0 ? d_we : (p_req && p_we)));
            if (g0 || p_req) begin
                chk("m_addr0",  {2'b00, m_addr0}, {2'b00, (g0 ? d_addr : p_addr)});
                chk("m_wmask0", 32'(m_wmask0),    32'(g0 ? d_wmask : p_wmask));
                chk("m_wdata0", m_wdata0,         g0 ? d_wdata : p_wdata);
            end
            if (p_req && !g0) chk("p_rdata0", p_rdata0, rom0(p_addr));
        end
        @(posedge clk);
        if (rst_mid) begin
            in_ack = 1'b0; in_ack0 = 1'b0; wait_cnt = 0;
            exp_drdata = 32'h0; exp_drdata0 = 32'h0; last_stall = 1'b0;
        end else begin
            // count how many P wins D has sat through while eligible
            if (g || !d_req) wait_cnt = 0;
            else if (!in_ack && p_req && wait_cnt < SMAX) wait_cnt = wait_cnt + 1;
            if (g) begin
                exp_drdata = ref_mem[d_addr[5:0]];
                if (d_we) ref_mem[d_addr[5:0]] = merge(ref_mem[d_addr[5:0]], d_wdata, d_wmask);
            end else if (p_req && p_we) begin
                ref_mem[p_addr[5:0]] = merge(ref_mem[p_addr[5:0]], p_wdata, p_wmask);
            end
            if (g0) exp_drdata0 = rom0(d_addr);
            last_stall = p_req && g;
            in_ack  = g;
            in_ack0 = g0;
        end
        #1;
    endtask

    task automatic set_p(input logic req, input logic we, input logic [3:0] mask,
                         input logic [29:0] addr, input logic [31:0] data);
        p_req = req; p_we = we; p_wmask = mask; p_addr = addr; p_wdata = data;
    endtask

    task automatic set_d(input logic req, input logic we, input logic [3:0] mask,
                         input logic [29:0] addr, input logic [31:0] data);
        d_req = req; d_we = we; d_wmask = mask; d_addr = addr; d_wdata = data;
    endtask

    initial begin
        rst = 1'b1; mem_init = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        in_ack = 1'b0; in_ack0 = 1'b0; wait_cnt = 0; last_stall = 1'b0; pend_new = 1'b0;
        exp_drdata = 32'h0; exp_drdata0 = 32'h0;
        // requests active during reset must not reach memory or stall P
        set_p(1'b1, 1'b1, 4'hF, 30'd1, 32'hFFFF_FFFF);
        set_d(1'b1, 1'b1, 4'hF, 30'd2, 32'hEEEE_EEEE);
        repeat (2) @(posedge clk);
        #6;
        chk("reset_m_we",    32'(m_we),    32'h0);
        chk("reset_p_stall", 32'(p_stall), 32'h0);
        chk("reset_d_ack",   32'(d_ack),   32'h0);
        chk("reset_d_rdata", d_rdata,      32'h0);
        @(posedge clk); #1;
        rst = 1'b0; mem_init = 1'b0;

        // P store, D idle
        set_p(1'b1, 1'b1, 4'b0011, 30'd5, 32'hAAAA_5555);
        set_d(1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
        cycle(1'b0);
        chk("t1_mem5", mem[5], merge(init_val(5), 32'hAAAA_5555, 4'b0011));

        // D read with P idle, held through the ACK cycle
        set_p(1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
        set_d(1'b1, 1'b0, 4'h0, 30'h10, 32'h0);
        cycle(1'b0);
        chk("t2_ack", 32'(d_ack), 32'h1);
        chk("t2_rdata", d_rdata, 32'h1234_5678);
        cycle(1'b0);
        set_d(1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
        cycle(1'b0);
        chk("t2_ack_low", 32'(d_ack), 32'h0);

        // both masters held: four P grants, then D, then P again in ACK
        set_p(1'b1, 1'b0, 4'h0, 30'd3, 32'h0);
        set_d(1'b1, 1'b0, 4'h0, 30'd2, 32'h0);
        repeat (6) cycle(1'b0);
        set_d(1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
        cycle(1'b0);

        // D rises while P is busy: the strict-priority instance grants at once
        set_d(1'b1, 1'b0, 4'h0, 30'd4, 32'h0);
        cycle(1'b0);
        chk("t4_ack0", 32'(d_ack0), 32'h1);
        set_d(1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
        repeat (5) cycle(1'b0);

        // D write then P read of the same word
        set_p(1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
        set_d(1'b1, 1'b1, 4'hF, 30'd7, 32'hCAFE_F00D);
        repeat (2) cycle(1'b0);
        set_d(1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
        set_p(1'b1, 1'b0, 4'h0, 30'd7, 32'h0);
        cycle(1'b0);
        chk("t5_p_rdata", p_rdata, 32'hCAFE_F00D);

        // starve D a little, then reset during a D write grant
        set_d(1'b1, 1'b0, 4'h0, 30'd8, 32'h0);
        repeat (2) cycle(1'b0);
        set_p(1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
        set_d(1'b1, 1'b1, 4'hF, 30'd9, 32'hDEAD_BEEF);
        cycle(1'b1);
        rst = 1'b0;
        chk("t6_mem9", mem[9], init_val(9));
        // counter restarted from zero: D waits four P grants again
        set_p(1'b1, 1'b0, 4'h0, 30'd1, 32'h0);
        set_d(1'b1, 1'b0, 4'h0, 30'd9, 32'h0);
        repeat (6) cycle(1'b0);
        set_d(1'b0, 1'b0, 4'h0, 30'd0, 32'h0);
        cycle(1'b0);
        pend_new = 1'b0;

        // randomized traffic with occasional reset
        for (int n = 0; n < 400; n++) begin
            bit r;
            if (!last_stall) begin
                set_p(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
                      4'($urandom), 30'($urandom_range(0, 15)), $urandom);
            end
            if (in_ack) begin
                pend_new = 1'b1;
            end else if (pend_new || !d_req) begin
                pend_new = 1'b0;
                set_d(($urandom_range(0, 2) != 0), $urandom_range(0, 1) == 1,
                      4'($urandom), 30'($urandom_range(0, 15)), $urandom);
            end
            r = ($urandom_range(0, 99) == 0);
            cycle(r);
            if (r) rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
